// File: rtl/la_capture_export_sequencer.sv
// Acquisition sequencer: arms the capture engine, latches the trigger index on capture done,
// runs one streamer frame, then stops (single) or rearms after a holdoff (run).
`timescale 1ns/1ps
module la_capture_export_sequencer #(
  parameter int ADDR_WIDTH     = 11,
  parameter int HOLDOFF_CYCLES = 50_000,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_single,
  input  logic                  cmd_run,
  input  logic                  cmd_abort,
  output logic                  cap_arm,
  output logic                  cap_abort,
  input  logic                  cap_done,
  input  logic [ADDR_WIDTH-1:0] cap_trig_index,
  output logic                  stream_start,
  input  logic                  stream_busy,
  input  logic                  stream_done,
  output logic [ADDR_WIDTH-1:0] trig_index,
  output logic                  seq_busy,
  output logic [2:0]            seq_state,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPT    = 3'd2,
    S_EXPORT  = 3'd3,
    S_RELEASE = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST  = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] trig_index_q, trig_index_d;
  logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  stream_start_q, stream_start_d;
  logic                  cap_abort_q, cap_abort_d;
  logic                  timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      hold_q         <= '0;
      trig_index_q   <= '0;
      frame_count_q  <= '0;
      timeout_err_q  <= 1'b0;
      abort_pend_q   <= 1'b0;
      stream_start_q <= 1'b0;
      cap_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
      trig_index_q   <= trig_index_d;
      frame_count_q  <= frame_count_d;
      timeout_err_q  <= timeout_err_d;
      abort_pend_q   <= abort_pend_d;
      stream_start_q <= stream_start_d;
      cap_abort_q    <= cap_abort_d;
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST);

  // abort_pend latches any stop request so a still-high cmd_run cannot relaunch;
  // it clears once cmd_run drops in idle or a new start is accepted.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    hold_d        = hold_q;
    trig_index_d  = trig_index_q;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    abort_pend_d  = abort_pend_q;
    cap_abort_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_abort) begin
          abort_pend_d = 1'b1;
        end else if (cmd_single || (cmd_run && !abort_pend_q)) begin
          state_d       = S_ARM;
          timeout_err_d = 1'b0;
          abort_pend_d  = 1'b0;
        end else if (!cmd_run) begin
          abort_pend_d = 1'b0;
        end
      end
      S_ARM: begin
        timer_d = '0;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        timer_d = timer_q + 1'b1;
        if (cmd_abort) begin
          cap_abort_d  = 1'b1;
          abort_pend_d = 1'b1;
          state_d      = S_IDLE;
        end else if (timeout_hit) begin
          cap_abort_d   = 1'b1;
          timeout_err_d = 1'b1;
          abort_pend_d  = 1'b1;
          state_d       = S_IDLE;
        end else if (cap_done) begin
          trig_index_d = cap_trig_index;
          state_d      = S_EXPORT;
        end
      end
      S_EXPORT: begin
        if (cmd_abort) abort_pend_d = 1'b1;
        if (stream_done) begin
          frame_count_d = frame_count_q + 1'b1;
          state_d       = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (cmd_abort) abort_pend_d = 1'b1;
        if (!stream_busy && !stream_done) begin
          if (abort_pend_q || cmd_abort || !cmd_run) begin
            state_d = S_IDLE;
          end else begin
            hold_d  = HOLD_LAST;
            state_d = S_HOLDOFF;
          end
        end
      end
      S_HOLDOFF: begin
        if (cmd_abort) abort_pend_d = 1'b1;
        if (cmd_abort || !cmd_run) begin
          state_d = S_IDLE;
        end else if (hold_q == '0) begin
          state_d = S_ARM;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // start rises one cycle after entering export and drops as soon as export is left
    stream_start_d = (state_q == S_EXPORT) && (state_d == S_EXPORT);
  end

  always_comb begin
    cap_arm  = (state_q == S_ARM);
    seq_busy = (state_q != S_IDLE);
  end

  assign cap_abort    = cap_abort_q;
  assign stream_start = stream_start_q;
  assign trig_index   = trig_index_q;
  assign seq_state    = state_q;
  assign frame_count  = frame_count_q;
  assign timeout_err  = timeout_err_q;

endmodule
